multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: COUNT_WIDTH, default 32, width of retired-instruction counter.
REQ-002 clk  input  1  system clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 OP  input  6  opcode from instruction register [31:26].
REQ-005 Funct  input  6  function field from instruction register [5:0].
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 MemReady  input  1  memory access complete this cycle.
REQ-008 Outputs, 1 bit each: PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, Illegal.
REQ-009 Outputs: RegDst 2 (00 rt, 01 rd, 10 $31), MemtoReg 2 (00 ALUOut, 01 MDR, 10 PC), ALUSrcB 2 (00 reg, 01 const 4, 10 imm, 11 imm<<2), PCSource 2 (00 ALU, 01 ALUOut, 10 jump target, 11 rs), ALUOp 3 (000 add, 001 sub, 010 and, 011 or, 100 lui, 111 R-type by funct).
REQ-010 State  output  4  current state encoding; InstrCount  output  COUNT_WIDTH  retired instructions.

Function
REQ-011 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, JAL, JR.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=MemReady; to DECODE when MemReady=1, else hold.
REQ-013 DECODE: ALUSrcB=11, ALUOp=000 (branch target to ALUOut); next state by OP: 0x00->EXEC_R (JR if Funct=0x08), 0x23/0x2B->MEMADR, 0x08/0x0C/0x0D/0x0F->EXEC_I, 0x04/0x05->BRANCH, 0x02->JUMP, 0x03->JAL, other->FETCH with Illegal=1 for that cycle.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; to MEMRD (0x23) or MEMWR (0x2B).
REQ-015 MEMRD: MemRead=1, IorD=1; hold until MemReady, then MEMWB. MEMWB: RegWrite=1, RegDst=00, MemtoReg=01; to FETCH.
REQ-016 MEMWR: MemWrite=1, IorD=1; hold until MemReady, then FETCH.
REQ-017 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111; RWB: RegWrite=1, RegDst=01, MemtoReg=00; to FETCH.
REQ-018 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp 000/010/011/100 for addi/andi/ori/lui; IWB: RegWrite=1, RegDst=00, MemtoReg=00; to FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWrite=(OP=0x04 & Zero)|(OP=0x05 & ~Zero), combinational in that cycle; to FETCH.
REQ-020 JUMP: PCSource=10, PCWrite=1; to FETCH. JAL: PCSource=10, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10; to FETCH. JR: PCSource=11, PCWrite=1; to FETCH.
REQ-021 Unlisted outputs are 0 in every state; MemRead and MemWrite never both 1.
REQ-022 Cycles per instruction with MemReady tied 1: R/addi/sw 4, lw 5, beq/bne/j/jal/jr 3; each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one.
REQ-023 InstrCount increments by 1 on every transition into FETCH from a non-FETCH state except the Illegal path; wraps modulo 2^COUNT_WIDTH.

Reset
REQ-024 reset=1 forces State=FETCH and InstrCount=0 immediately, regardless of clk, including mid-instruction or mid-wait.
REQ-025 On reset, registered outputs reset to 0; while State=FETCH the FETCH decode of REQ-012 applies.

Configuration
REQ-026 Macro MULTICYCLE_JAL_JR_EN: defined -> JAL and JR states present per REQ-013/REQ-020.
REQ-027 Undefined -> OP=0x03 and R-type Funct=0x08 take the Illegal path: FETCH next, Illegal=1 one cycle, no RegWrite/PCWrite; JAL/JR states absent.

Structure
REQ-028 Shared package mips_ctrl_pkg holds the state enum, opcode/funct constants and ALUOp, RegDst, MemtoReg, ALUSrcB, PCSource encodings.
REQ-029 One sub-module, mc_output_decode: combinational state/OP/Zero/MemReady to control outputs; the top module holds the state register, next-state logic and counter.

Verification
REQ-030 reset pulse mid-MEMRD -> State=FETCH and InstrCount=0 asynchronously; next instruction fetched normally.
REQ-031 lw (OP=0x23), MemReady=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB in 5 cycles; RegWrite=1, MemtoReg=01 only in MEMWB; InstrCount +1.
REQ-032 sw with MemReady low 3 cycles in MEMWR -> MemWrite held 4 cycles, IorD=1 throughout, then FETCH.
REQ-033 beq with Zero=1 -> PCWrite=1, PCSource=01 in BRANCH; bne with Zero=1 -> PCWrite=0.
REQ-034 OP=0x3F -> Illegal=1 in DECODE cycle, then FETCH, no RegWrite, InstrCount unchanged.
REQ-035 jal with and without MULTICYCLE_JAL_JR_EN -> with: RegDst=10, MemtoReg=10, PCWrite=1 in JAL; without: Illegal path per REQ-027.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared state enum, opcode/funct constants and control-field
//                encodings for the multicycle MIPS controller.
//                Optional JAL/JR support follows MULTICYCLE_JAL_JR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    // Opcodes and the one funct value the controller cares about
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FUNCT_JR = 6'h08;

    // ALUOp
    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_AND   = 3'b010;
    localparam logic [2:0] c_ALU_OR    = 3'b011;
    localparam logic [2:0] c_ALU_LUI   = 3'b100;
    localparam logic [2:0] c_ALU_RTYPE = 3'b111;

    // RegDst
    localparam logic [1:0] c_RD_RT  = 2'b00;
    localparam logic [1:0] c_RD_RD  = 2'b01;
    localparam logic [1:0] c_RD_R31 = 2'b10;

    // MemtoReg
    localparam logic [1:0] c_MTR_ALUOUT = 2'b00;
    localparam logic [1:0] c_MTR_MDR    = 2'b01;
    localparam logic [1:0] c_MTR_PC     = 2'b10;

    // ALUSrcB
    localparam logic [1:0] c_SRCB_REG   = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    // PCSource
    localparam logic [1:0] c_PCS_ALU    = 2'b00;
    localparam logic [1:0] c_PCS_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCS_JUMP   = 2'b10;
    localparam logic [1:0] c_PCS_RS     = 2'b11;

`ifdef MULTICYCLE_JAL_JR_EN
    localparam bit c_JAL_JR_EN = 1'b1;
`else
    localparam bit c_JAL_JR_EN = 1'b0;
`endif

    // True when the decoded instruction has a datapath sequence; everything
    // else retires through the Illegal path straight back to FETCH.
    function automatic logic isLegal(input logic [5:0] op, input logic [5:0] funct);
        logic legal;
        case (op)
            c_OP_RTYPE: legal = c_JAL_JR_EN || (funct != c_FUNCT_JR);
            c_OP_LW, c_OP_SW,
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI,
            c_OP_BEQ, c_OP_BNE, c_OP_J: legal = 1'b1;
            c_OP_JAL:   legal = c_JAL_JR_EN;
            default:    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_output_decode
//  Description : Combinational control-signal decode from current state,
//                opcode, ALU zero flag and memory handshake.
//                JAL/JR decode present only with MULTICYCLE_JAL_JR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic       [5:0] OP,
    input  logic       [5:0] Funct,
    input  logic             Zero,
    input  logic             MemReady,
    input  state_t           State,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             Illegal,
    output logic       [1:0] RegDst,
    output logic       [1:0] MemtoReg,
    output logic       [1:0] ALUSrcB,
    output logic       [1:0] PCSource,
    output logic       [2:0] ALUOp
);

    // Per-state control decode; every output defaults to its idle value
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        Illegal  = 1'b0;
        RegDst   = c_RD_RT;
        MemtoReg = c_MTR_ALUOUT;
        ALUSrcB  = c_SRCB_REG;
        PCSource = c_PCS_ALU;
        ALUOp    = c_ALU_ADD;
        case (State)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = c_SRCB_FOUR;
                // PC+4 and the IR are only captured once the read completes
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = c_SRCB_IMMSH;
                Illegal = !isLegal(OP, Funct);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = c_MTR_MDR;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = c_ALU_RTYPE;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = c_RD_RD;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_SRCB_IMM;
                case (OP)
                    c_OP_ANDI: ALUOp = c_ALU_AND;
                    c_OP_ORI:  ALUOp = c_ALU_OR;
                    c_OP_LUI:  ALUOp = c_ALU_LUI;
                    default:   ALUOp = c_ALU_ADD;
                endcase
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = c_ALU_SUB;
                PCSource = c_PCS_ALUOUT;
                PCWrite  = ((OP == c_OP_BEQ) && Zero) || ((OP == c_OP_BNE) && !Zero);
            end
            S_JUMP: begin
                PCSource = c_PCS_JUMP;
                PCWrite  = 1'b1;
            end
`ifdef MULTICYCLE_JAL_JR_EN
            S_JAL: begin
                PCSource = c_PCS_JUMP;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = c_RD_R31;
                MemtoReg = c_MTR_PC;
            end
            S_JR: begin
                PCSource = c_PCS_RS;
                PCWrite  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle MIPS control unit: state register, next-state
//                logic and retired-instruction counter. Control outputs come
//                from mc_output_decode.
//                Define MULTICYCLE_JAL_JR_EN to enable the JAL and JR states.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic             [5:0] OP,
    input  logic             [5:0] Funct,
    input  logic                   Zero,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic                   Illegal,
    output logic             [1:0] RegDst,
    output logic             [1:0] MemtoReg,
    output logic             [1:0] ALUSrcB,
    output logic             [1:0] PCSource,
    output logic             [2:0] ALUOp,
    output logic             [3:0] State,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

    state_t                 r_state;
    state_t                 w_nextState;
    logic                   w_illegal;
    logic [COUNT_WIDTH-1:0] r_instrCount;

    // State register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection; wait states hold until MemReady
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: begin
                if (MemReady) w_nextState = S_DECODE;
            end
            S_DECODE: begin
                if (!isLegal(OP, Funct)) begin
                    w_nextState = S_FETCH;
                end else begin
                    case (OP)
`ifdef MULTICYCLE_JAL_JR_EN
                        c_OP_RTYPE: w_nextState = (Funct == c_FUNCT_JR) ? S_JR : S_EXEC_R;
                        c_OP_JAL:   w_nextState = S_JAL;
`else
                        c_OP_RTYPE: w_nextState = S_EXEC_R;
`endif
                        c_OP_LW, c_OP_SW: w_nextState = S_MEMADR;
                        c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: w_nextState = S_EXEC_I;
                        c_OP_BEQ, c_OP_BNE: w_nextState = S_BRANCH;
                        c_OP_J:     w_nextState = S_JUMP;
                        default:    w_nextState = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: w_nextState = (OP == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (MemReady) w_nextState = S_MEMWB;
            end
            S_MEMWR: begin
                if (MemReady) w_nextState = S_FETCH;
            end
            S_EXEC_R: w_nextState = S_RWB;
            S_EXEC_I: w_nextState = S_IWB;
            default:  w_nextState = S_FETCH;
        endcase
    end

    // Retire count: any return to FETCH except an illegal-opcode bounce
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instrCount <= '0;
        end else if ((r_state != S_FETCH) && (w_nextState == S_FETCH) && !w_illegal) begin
            r_instrCount <= r_instrCount + COUNT_WIDTH'(1);
        end
    end

    mc_output_decode u_decode (
        .OP       (OP),
        .Funct    (Funct),
        .Zero     (Zero),
        .MemReady (MemReady),
        .State    (r_state),
        .PCWrite  (PCWrite),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .Illegal  (w_illegal),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .ALUSrcB  (ALUSrcB),
        .PCSource (PCSource),
        .ALUOp    (ALUOp)
    );

    assign Illegal    = w_illegal;
    assign State      = r_state;
    assign InstrCount = r_instrCount;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Scoreboard bench for multicycle_control: the driver issues
//                whole instructions and queues the expected per-cycle control
//                word; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int CW = 4;

    typedef struct packed {
        logic [3:0]    st;
        logic [CW-1:0] cnt;
        logic pcWrite, iorD, memRead, memWrite, irWrite, regWrite, aluSrcA, illegal;
        logic [1:0] regDst, memtoReg, aluSrcB, pcSource;
        logic [2:0] aluOp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] OP = '0;
    logic [5:0] Funct = '0;
    logic Zero = 1'b0;
    logic MemReady = 1'b0;
    logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, Illegal;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic [CW-1:0] InstrCount;

    int total = 0;
    int bad = 0;
    int modelCount = 0;
    int cycleNo = 0;
    exp_t q[$];

    multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .Illegal(Illegal), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .State(State), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    // Monitor: one expected control word per clock cycle
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        cycleNo++;
        if (!reset && q.size() > 0) begin
            e = q.pop_front();
            a = {State, InstrCount, PCWrite, IorD, MemRead, MemWrite, IRWrite,
                 RegWrite, ALUSrcA, Illegal, RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d ctrl: got st=%0d cnt=%0d word=%h, want st=%0d cnt=%0d word=%h",
                         cycleNo, a.st, a.cnt, a, e.st, e.cnt, e);
            end
        end
    end

    // Reference legality straight from the instruction list
    function automatic bit tbLegal(input logic [5:0] op, input logic [5:0] fn);
        bit jj;
`ifdef MULTICYCLE_JAL_JR_EN
        jj = 1'b1;
`else
        jj = 1'b0;
`endif
        if (op == 6'h00) return jj || (fn != 6'h08);
        if (op == 6'h03) return jj;
        return op inside {6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02};
    endfunction

    function automatic exp_t base(input state_t s);
        exp_t e;
        e = '0;
        e.st = s;
        e.cnt = CW'(modelCount);
        return e;
    endfunction

    task automatic cyc(input exp_t e, input logic mr);
        MemReady = mr;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd(input exp_t e);
        cyc(e, 1'($urandom_range(0, 1)));
    endtask

    // Issue one instruction; resetAt>=0 pulses reset after that many MEMRD waits
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fStall, input int mStall, input int resetAt);
        exp_t e;
        OP = op; Funct = fn; Zero = z;
        e = base(S_FETCH); e.memRead = 1'b1; e.aluSrcB = 2'b01;
        for (int i = 0; i < fStall; i++) cyc(e, 1'b0);
        e.irWrite = 1'b1; e.pcWrite = 1'b1;
        cyc(e, 1'b1);
        e = base(S_DECODE); e.aluSrcB = 2'b11; e.illegal = !tbLegal(op, fn);
        rnd(e);
        if (!tbLegal(op, fn)) return;
        if (op == 6'h23 || op == 6'h2B) begin
            e = base(S_MEMADR); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
            rnd(e);
            e = base(op == 6'h23 ? S_MEMRD : S_MEMWR); e.iorD = 1'b1;
            if (op == 6'h23) e.memRead = 1'b1; else e.memWrite = 1'b1;
            for (int i = 0; i < mStall; i++) begin
                if (i == resetAt) begin
                    MemReady = 1'b0;
                    #5 reset = 1'b1;
                    #1;
                    total++;
                    if (State !== S_FETCH || InstrCount !== '0 || MemRead !== 1'b1 || MemWrite !== 1'b0) begin
                        bad++;
                        $display("FAIL async_reset: got st=%0d cnt=%0d rd=%b wr=%b, want st=0 cnt=0 rd=1 wr=0",
                                 State, InstrCount, MemRead, MemWrite);
                    end
                    #1 reset = 1'b0;
                    @(posedge clk);
                    #1;
                    modelCount = 0;
                    return;
                end
                cyc(e, 1'b0);
            end
            cyc(e, 1'b1);
            if (op == 6'h23) begin
                e = base(S_MEMWB); e.regWrite = 1'b1; e.memtoReg = 2'b01;
                rnd(e);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            e = base(S_JR); e.pcSource = 2'b11; e.pcWrite = 1'b1;
            rnd(e);
        end else if (op == 6'h00) begin
            e = base(S_EXEC_R); e.aluSrcA = 1'b1; e.aluOp = 3'b111;
            rnd(e);
            e = base(S_RWB); e.regWrite = 1'b1; e.regDst = 2'b01;
            rnd(e);
        end else if (op == 6'h04 || op == 6'h05) begin
            e = base(S_BRANCH); e.aluSrcA = 1'b1; e.aluOp = 3'b001; e.pcSource = 2'b01;
            e.pcWrite = (op == 6'h04) ? z : !z;
            rnd(e);
        end else if (op == 6'h02) begin
            e = base(S_JUMP); e.pcSource = 2'b10; e.pcWrite = 1'b1;
            rnd(e);
        end else if (op == 6'h03) begin
            e = base(S_JAL); e.pcSource = 2'b10; e.pcWrite = 1'b1; e.regWrite = 1'b1;
            e.regDst = 2'b10; e.memtoReg = 2'b10;
            rnd(e);
        end else begin
            e = base(S_EXEC_I); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
            e.aluOp = (op == 6'h0C) ? 3'b010 : (op == 6'h0D) ? 3'b011 :
                      (op == 6'h0F) ? 3'b100 : 3'b000;
            rnd(e);
            e = base(S_IWB); e.regWrite = 1'b1;
            rnd(e);
        end
        modelCount = (modelCount + 1) % (1 << CW);
    endtask

    initial begin
        logic [5:0] ops [13];
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F,
                6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (State !== S_FETCH || InstrCount !== '0 || MemRead !== 1'b1 || ALUSrcB !== 2'b01 || IRWrite !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got st=%0d cnt=%0d rd=%b srcb=%b ir=%b, want st=0 cnt=0 rd=1 srcb=01 ir=0",
                     State, InstrCount, MemRead, ALUSrcB, IRWrite);
        end
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        // Directed cases
        runInstr(6'h23, 6'h00, 1'b0, 0, 0, -1);  // lw, no stalls
        runInstr(6'h2B, 6'h00, 1'b0, 1, 3, -1);  // sw, 3 write stalls
        runInstr(6'h04, 6'h00, 1'b1, 0, 0, -1);  // beq taken
        runInstr(6'h05, 6'h00, 1'b1, 0, 0, -1);  // bne not taken
        runInstr(6'h3F, 6'h00, 1'b0, 0, 0, -1);  // illegal
        runInstr(6'h03, 6'h00, 1'b0, 0, 0, -1);  // jal
        runInstr(6'h00, 6'h08, 1'b0, 0, 0, -1);  // jr
        runInstr(6'h23, 6'h00, 1'b0, 0, 3, 1);   // reset during MEMRD wait
        runInstr(6'h00, 6'h20, 1'b0, 0, 0, -1);  // normal R after reset
        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            int k;
            logic [5:0] op;
            logic [5:0] fn;
            k = $urandom_range(0, 12);
            op = ops[k];
            fn = (k == 1) ? 6'h08 : 6'($urandom_range(0, 63));
            if (k == 0 && fn == 6'h08) fn = 6'h20;
            if (k == 12) op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h10;
            runInstr(op, fn, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end
        #10;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
